// File: rtl/uart_clk_rst_gen.sv
// Fractional phase-accumulator baud tick generator with a counted reset stretcher.
// Optional macro UART_CLKGEN_BITCNT_EN adds a 16-bit bit-tick counter output o_bit_cnt.
module uart_clk_rst_gen #(
    parameter int unsigned       ACC_W       = 32,
    parameter int unsigned       OVERSAMPLE  = 16,
    parameter logic [ACC_W-1:0]  INC_DEFAULT = ACC_W'(79164837),
    parameter int unsigned       RST_HOLD    = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tick_en,
    input  logic                          i_inc_wr,
    input  logic [ACC_W-1:0]              i_inc,
    output logic                          o_rst,
    output logic                          o_os_tick,
    output logic                          o_bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_os_cnt
`ifdef UART_CLKGEN_BITCNT_EN
    ,
    output logic [15:0]                   o_bit_cnt
`endif
);

    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  inc_q, inc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rst_q, rst_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic [ACC_W:0]    sum;
    logic              run;
    logic              os_last;

    // Reset stretcher: o_rst drops on the edge where hold_cnt has counted RST_HOLD-1.
    always_comb begin
        rst_d      = rst_q;
        hold_cnt_d = hold_cnt_q;
        if (rst_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                rst_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // The carry out of the wide add is the oversample tick; an increment write
    // restarts the phase and suppresses whatever that cycle's add would have produced.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, inc_q};
        run        = !rst_q && i_tick_en;
        os_last    = (os_cnt_q == OS_LAST);
        inc_d      = inc_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        if (i_inc_wr) begin
            inc_d    = i_inc;
            acc_d    = '0;
            os_cnt_d = '0;
        end else if (run) begin
            acc_d      = sum[ACC_W-1:0];
            os_tick_d  = sum[ACC_W];
            bit_tick_d = sum[ACC_W] && os_last;
            if (sum[ACC_W]) begin
                os_cnt_d = os_last ? '0 : os_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q      <= '0;
            inc_q      <= INC_DEFAULT;
            os_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rst_q      <= 1'b1;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            os_cnt_q   <= os_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rst_q      <= rst_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

`ifdef UART_CLKGEN_BITCNT_EN
    logic [15:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (i_inc_wr) begin
            bit_cnt_d = '0;
        end else if (bit_tick_d) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign o_bit_cnt = bit_cnt_q;
`endif

    assign o_rst      = rst_q;
    assign o_os_tick  = os_tick_q;
    assign o_bit_tick = bit_tick_q;
    assign o_os_cnt   = os_cnt_q;

endmodule

// File: doc/uart_clk_rst_gen.md
Name: uart_clk_rst_gen

Overview:
- Parametrised, synthesizable clock-enable and reset generator for the UART/CORDIC datapath.
- Replaces a fixed free-running baud clock and a fixed-width reset pulse with:
  - a fractional phase-accumulator baud generator: oversample tick plus bit tick, divisor programmable at runtime;
  - a counted reset stretcher.
- Sits beside the UART RX/TX engines. All outputs are single-cycle enables in the i_clk domain; no derived clocks.

Parameters:
- ACC_W, 32: phase accumulator width.
- OVERSAMPLE, 16: oversample ticks per bit tick; must be ≥2.
- INC_DEFAULT, 79164837: reset increment = round(115200*16*2^32/100e6).
- RST_HOLD, 16: i_clk cycles o_rst stays high after i_rst deasserts; must be ≥1.

Ports:
- i_clk, in, 1: system clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_tick_en, in, 1: tick generation enable; low freezes the accumulator and oversample count.
- i_inc_wr, in, 1: load strobe for i_inc.
- i_inc, in, ACC_W: new phase increment.
- o_rst, out, 1: stretched synchronous active-high reset for downstream logic.
- o_os_tick, out, 1: oversample enable, 1-cycle pulse.
- o_bit_tick, out, 1: bit-rate enable, 1-cycle pulse.
- o_os_cnt, out, $clog2(OVERSAMPLE): oversample phase within the current bit.

Behaviour:
- **Reset (i_rst=1 at a clock edge):**
  - acc=0, inc=INC_DEFAULT, os_cnt=0, hold_cnt=0.
  - o_rst=1, o_os_tick=0, o_bit_tick=0.
  - Reset mid-operation aborts everything the same way, including an in-progress hold.
- **Reset stretch:**
  - While i_rst=0 and o_rst=1, hold_cnt increments each cycle.
  - o_rst falls on the edge where hold_cnt reaches RST_HOLD-1. The first cycle with o_rst=0 is therefore RST_HOLD cycles after the first cycle with i_rst=0.
- **Run condition:** run = !o_rst && i_tick_en. When run=0:
  - acc and os_cnt hold their values;
  - o_os_tick=0 and o_bit_tick=0 (registered).
- **Accumulator:** when run=1, {carry, acc} <= acc + inc, computed at ACC_W+1 bits. Overflow wraps; the carry is the tick.
- **Oversample tick:** o_os_tick <= carry, so latency is 1 cycle from the wrapping add.
  - inc=0: no ticks ever.
  - inc ≥ 2^(ACC_W-1): up to one tick every cycle. No tick is dropped and none is doubled, because inc < 2^ACC_W.
- **Oversample count:** on carry, os_cnt <= (os_cnt==OVERSAMPLE-1) ? 0 : os_cnt+1.
  - o_bit_tick <= carry && (os_cnt==OVERSAMPLE-1), so it is coincident with the o_os_tick pulse that wraps o_os_cnt to 0.
  - o_os_cnt is the registered value after the update.
- **Increment write (i_inc_wr=1, i_rst=0):**
  - inc <= i_inc, acc <= 0, os_cnt <= 0 (phase restart).
  - No tick is produced from that cycle's add, even if it would carry; the write has priority.
  - Accepted even while o_rst=1 or i_tick_en=0.
- **Simultaneous i_rst and i_inc_wr:** reset wins; inc = INC_DEFAULT.
- **Timing:** no combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: UART_CLKGEN_BITCNT_EN.
- **Defined:** adds output port o_bit_cnt, 16 bits.
  - Increments on every o_bit_tick pulse (same edge the pulse is registered) and wraps 0xFFFF→0.
  - Cleared by i_rst and by an accepted i_inc_wr.
- **Undefined:** port and counter absent; all other behaviour identical.

Test Plan:
- **Reset stretch:** assert i_rst 5 cycles, release (RST_HOLD=16) → o_rst high exactly 16 cycles after release; o_os_tick=o_bit_tick=0 throughout.
- **Integer rate:** after reset, write i_inc=0x4000_0000, i_tick_en=1 → o_os_tick every 4th cycle; o_bit_tick every 64 cycles, coincident with o_os_cnt returning to 0.
- **Default rate:** run INC_DEFAULT for 10^7 cycles → o_os_tick count = 184320±1, o_bit_tick count = 11520±1; tick spacing is only 54 or 55 cycles.
- **Enable freeze:** with inc=0x4000_0000, drop i_tick_en for 7 cycles mid-bit → no pulses; o_os_cnt is unchanged; cadence resumes with the same phase.
- **Write/reset collisions:**
  - i_inc_wr on a cycle whose add would carry → no tick that cycle; acc and o_os_cnt restart at 0.
  - i_rst together with i_inc_wr=0x1 → inc reads back as INC_DEFAULT behaviour.
- **Extremes:**
  - i_inc=0 → no ticks over 1000 cycles.
  - i_inc=0xFFFF_FFFF → o_os_tick high on all but one cycle per 2^32, i.e. continuously over 1000 cycles.
  - With UART_CLKGEN_BITCNT_EN, o_bit_cnt equals the number of o_bit_tick pulses.
